// File: rtl/code_lock_fsm.sv
// rtl/code_lock_fsm.sv - code comparison lock FSM with password change, retry count and lockout
module code_lock_fsm #(
    parameter int          Byte        = 4,
    parameter logic [15:0] PASSWORD    = 16'h1234,
    parameter int          MAX_TRY     = 3,
    parameter int          OPEN_CYCLES = 50_000_000,
    parameter int          LOCK_CYCLES = 100_000_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] Code,
    input  logic [2:0]  Code_Bit,
    input  logic        Enter,
    input  logic        Change,
    output logic        Unlock,
    output logic        Err_Flag,
    output logic        Locked,
    output logic        Clear_Req,
    output logic [2:0]  Try_Cnt,
    output logic [2:0]  State
);

    localparam int MAX_CYC = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);
    localparam logic [2:0]    CB_FULL   = 3'(Byte);
    localparam logic [2:0]    TRY_MAX   = 3'(MAX_TRY);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_OPEN   = 3'd2,
        S_ERROR  = 3'd3,
        S_LOCKED = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   code_q, code_d;
    logic [15:0]   pwd_q, pwd_d;
    logic [2:0]    try_q, try_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          unlock_q, unlock_d;
    logic          err_q, err_d;
    logic          locked_q, locked_d;
    logic          clr_q, clr_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            code_q   <= '0;
            pwd_q    <= PASSWORD;
            try_q    <= '0;
            timer_q  <= '0;
            unlock_q <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            pwd_q    <= pwd_d;
            try_q    <= try_d;
            timer_q  <= timer_d;
            unlock_q <= unlock_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            clr_q    <= clr_d;
        end
    end

    // Timer defaults to zero so every state change restarts it; dwelling states increment explicitly.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        pwd_d   = pwd_q;
        try_d   = try_q;
        timer_d = '0;
        err_d   = 1'b0;
        clr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Enter) begin
                    if (Code_Bit == CB_FULL) begin
                        code_d  = Code;
                        state_d = S_CHECK;
                    end else begin
                        err_d = 1'b1;
                        clr_d = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                clr_d = 1'b1;
                if (code_q == pwd_q) begin
                    try_d   = '0;
                    state_d = S_OPEN;
                end else if (try_q + 3'd1 >= TRY_MAX) begin
                    try_d   = TRY_MAX;
                    state_d = S_LOCKED;
                end else begin
                    try_d   = try_q + 3'd1;
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end
            end
            S_ERROR: state_d = S_IDLE;
            S_OPEN: begin
                if (Enter) begin
                    state_d = S_IDLE;
                end else if (Change && (Code_Bit == CB_FULL)) begin
                    pwd_d = Code;
                    clr_d = 1'b1;
                end else begin
                    err_d = Change;
                    if (timer_q == OPEN_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                if (timer_q == LOCK_LAST) begin
                    try_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        unlock_d = (state_d == S_OPEN);
        locked_d = (state_d == S_LOCKED);
    end

    assign State     = state_q;
    assign Unlock    = unlock_q;
    assign Err_Flag  = err_q;
    assign Locked    = locked_q;
    assign Clear_Req = clr_q;
    assign Try_Cnt   = try_q;

endmodule
